// File: rtl/niosii_system_switch_debouncer_if.sv
// Switch-conditioning bus between the raw pins and the PIO input side.
// The master drives the raw pins; the debouncer (slave) returns clean levels and edge pulses.
interface niosii_system_switch_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sw_changed;

    modport master (
        output sw_raw,
        input  sw_clean,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    modport slave (
        input  sw_raw,
        output sw_clean,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );
endinterface

// File: rtl/niosii_system_switch_debouncer.sv
// Per-bit two-flop synchroniser plus stability-counter debouncer for the DE2 slide switches.
// Produces a registered clean level and one-cycle rise/fall pulses for each bit.
module niosii_system_switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                              clk,
    input  logic                              reset_n,
    niosii_system_switch_debouncer_if.slave   sw_if
);

    localparam logic [CNT_W-1:0] LP_CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_changed;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_accept;

    always_comb begin
        w_diff   = '0;
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_diff[i]   = r_s2[i] ^ r_clean[i];
            w_accept[i] = w_diff[i] && (r_cnt[i] == LP_CNT_TC);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_clean   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_changed <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= sw_if.sw_raw;
            r_s2 <= r_s1;
            // Any return to the accepted level, or an accept itself, restarts the count.
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_diff[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_clean   <= r_clean ^ w_accept;
            r_rise    <= w_accept & r_s2;
            r_fall    <= w_accept & ~r_s2;
            r_changed <= |w_accept;
        end
    end

    assign sw_if.sw_clean   = r_clean;
    assign sw_if.sw_rise    = r_rise;
    assign sw_if.sw_fall    = r_fall;
    assign sw_if.sw_changed = r_changed;

endmodule

// File: tb/tb_niosii_system_switch_debouncer.sv
// Directed and randomized bench for the switch debouncer, checked every cycle
// against a streak-length reference model of the raw pin history.
module tb_niosii_system_switch_debouncer;

    localparam int W  = 8;
    localparam int DC = 4;
    localparam int CW = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    niosii_system_switch_debouncer_if #(.WIDTH(W)) sw_if ();

    niosii_system_switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (CW)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sw_if   (sw_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: raw samples seen two edges ago, and how long each bit has disagreed.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_clean, m_rise, m_fall;
    int           m_run [W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist    = {8'h00, 8'h00};
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] seen;
        if (!reset_n) begin
            model_reset();
        end else begin
            seen = hist[0];
            void'(hist.pop_front());
            hist.push_back(sw_if.sw_raw);
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (seen[i] != m_clean[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_clean[i] = seen[i];
                        if (seen[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        chk("clean",   32'(sw_if.sw_clean),   32'(m_clean));
        chk("rise",    32'(sw_if.sw_rise),    32'(m_rise));
        chk("fall",    32'(sw_if.sw_fall),    32'(m_fall));
        chk("changed", 32'(sw_if.sw_changed), 32'(|(m_rise | m_fall)));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int nr;
        int nf;
        int hold;
        model_reset();
        sw_if.sw_raw = 8'hFF;

        // 1: reset with all switches high, then power-up rise
        #1 reset_n = 1'b0;
        #1;
        chk("t1_rst_clean", 32'(sw_if.sw_clean), 0);
        chk("t1_rst_changed", 32'(sw_if.sw_changed), 0);
        repeat (10) cyc();
        reset_n = 1'b1;
        repeat (5) cyc();
        chk("t1_clean_early", 32'(sw_if.sw_clean), 0);
        cyc();
        chk("t1_clean", 32'(sw_if.sw_clean), 32'hFF);
        chk("t1_rise", 32'(sw_if.sw_rise), 32'hFF);
        chk("t1_changed", 32'(sw_if.sw_changed), 1);
        cyc();
        chk("t1_rise_clear", 32'(sw_if.sw_rise), 0);

        // 2: single rise from steady zero
        sw_if.sw_raw = 8'h00;
        repeat (12) cyc();
        sw_if.sw_raw = 8'h01;
        repeat (5) cyc();
        chk("t2_clean_early", 32'(sw_if.sw_clean), 0);
        cyc();
        chk("t2_clean", 32'(sw_if.sw_clean), 32'h01);
        chk("t2_rise", 32'(sw_if.sw_rise), 32'h01);
        chk("t2_changed", 32'(sw_if.sw_changed), 1);
        cyc();
        chk("t2_rise_clear", 32'(sw_if.sw_rise), 0);
        chk("t2_changed_clear", 32'(sw_if.sw_changed), 0);

        // 3: glitch of 3 cycles rejected, 4 cycles accepted
        repeat (4) cyc();
        sw_if.sw_raw = 8'h09;
        repeat (3) cyc();
        sw_if.sw_raw = 8'h01;
        repeat (10) cyc();
        chk("t3_short_clean", 32'(sw_if.sw_clean), 32'h01);
        sw_if.sw_raw = 8'h09;
        repeat (4) cyc();
        sw_if.sw_raw = 8'h01;
        cyc();
        cyc();
        chk("t3_long_rise", 32'(sw_if.sw_rise[3]), 1);
        repeat (3) cyc();
        chk("t3_long_hold", 32'(sw_if.sw_clean[3]), 1);
        cyc();
        chk("t3_long_fall", 32'(sw_if.sw_fall[3]), 1);
        chk("t3_long_clean", 32'(sw_if.sw_clean[3]), 0);

        // 4: bounce on bit 7, then settle high
        repeat (4) cyc();
        nr = 0;
        nf = 0;
        for (int seg = 0; seg < 10; seg++) begin
            sw_if.sw_raw = {~seg[0], 7'h01};
            repeat (2) begin
                cyc();
                nr += int'(sw_if.sw_rise[7]);
                nf += int'(sw_if.sw_fall[7]);
            end
        end
        sw_if.sw_raw = 8'h81;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            nr += int'(sw_if.sw_rise[7]);
            nf += int'(sw_if.sw_fall[7]);
            if (k == 5) chk("t4_rise_early", 32'(sw_if.sw_rise[7]), 0);
            if (k == 6) chk("t4_rise", 32'(sw_if.sw_rise[7]), 1);
        end
        chk("t4_rise_count", 32'(nr), 1);
        chk("t4_fall_count", 32'(nf), 0);

        // 5: many bits change together
        sw_if.sw_raw = 8'h0F;
        repeat (12) cyc();
        sw_if.sw_raw = 8'hF0;
        repeat (6) cyc();
        chk("t5_clean", 32'(sw_if.sw_clean), 32'hF0);
        chk("t5_rise", 32'(sw_if.sw_rise), 32'hF0);
        chk("t5_fall", 32'(sw_if.sw_fall), 32'h0F);
        chk("t5_changed", 32'(sw_if.sw_changed), 1);
        cyc();
        chk("t5_changed_clear", 32'(sw_if.sw_changed), 0);

        // 6: asynchronous reset part-way through a count
        sw_if.sw_raw = 8'h00;
        repeat (12) cyc();
        sw_if.sw_raw = 8'h01;
        repeat (4) cyc();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_clean", 32'(sw_if.sw_clean), 0);
        chk("t6_rst_rise", 32'(sw_if.sw_rise), 0);
        chk("t6_rst_changed", 32'(sw_if.sw_changed), 0);
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (5) cyc();
        chk("t6_clean_early", 32'(sw_if.sw_clean[0]), 0);
        cyc();
        chk("t6_clean", 32'(sw_if.sw_clean[0]), 1);
        chk("t6_rise", 32'(sw_if.sw_rise), 32'h01);

        // Randomized holds of random patterns, including sub-threshold glitches
        repeat (80) begin
            sw_if.sw_raw = sw_if.sw_raw ^ 8'($urandom & $urandom);
            hold = int'($urandom_range(1, 8));
            repeat (hold) cyc();
        end
        repeat (12) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
